// File: rtl/mc_controller.sv
// mc_controller: control unit for the multicycle processor datapath.
//
// A Moore FSM steps each instruction through fetch, decode, execute, memory
// and writeback. It drives every datapath select and write strobe. An ALU
// decoder turns the FSM's aluop plus the instruction funct field into the ALU
// operation. A memory-ready handshake stretches the FETCH, MEMRD and MEMWR
// cycles. A retired-instruction counter supports bench checking.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset (0 = in reset)
//   op[5:0]      in   opcode, IR[31:26]
//   funct[5:0]   in   function field, IR[5:0]
//   zero         in   ALU zero flag
//   memready     in   memory completes the current access this cycle
//   pcen         out  PC register enable
//   memwrite     out  data memory write strobe
//   irwrite      out  instruction register load
//   regwrite     out  register file write
//   iord         out  memory address source (0 = PC, 1 = ALUOut)
//   memtoreg     out  register write data source (0 = ALUOut, 1 = MDR)
//   regdst       out  destination register (0 = rt, 1 = rd)
//   alusrca      out  ALU A input (0 = PC, 1 = register A)
//   alusrcb[1:0] out  ALU B input (B, 4, imm, imm << 2)
//   pcsrc[1:0]   out  next-PC source (ALU result, ALUOut, jump target)
//   alucontrol   out  ALU operation
//   illegal      out  one-cycle pulse in DECODE for an unsupported opcode
//   instret      out  count of retired instructions (wraps)
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        memready,
    output logic        pcen,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regwrite,
    output logic        iord,
    output logic        memtoreg,
    output logic        regdst,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;

    // State-only selects are registered from the next state so they come
    // straight off flops; their reset values are the FETCH values.
    logic       iord_q, iord_d;
    logic       memtoreg_q, memtoreg_d;
    logic       regdst_q, regdst_d;
    logic       alusrca_q, alusrca_d;
    logic [1:0] alusrcb_q, alusrcb_d;
    logic [1:0] pcsrc_q, pcsrc_d;
    logic [1:0] aluop_q, aluop_d;

    logic op_legal;
    logic pcwrite;
    logic branch;
    logic retire;

    always_comb begin
        op_legal = 1'b0;
        unique case (op)
            OpLw, OpSw, OpRtype, OpBeq, OpAddi, OpJ: op_legal = 1'b1;
            default:                                 op_legal = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (memready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                unique case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtypeEx;
                    OpBeq:      state_d = StBeqEx;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJEx;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (op == OpSw) ? StMemWr : StMemRd;
            StMemRd:   state_d = memready ? StMemWb : StMemRd;
            StMemWb:   state_d = StFetch;
            StMemWr:   state_d = memready ? StFetch : StMemWr;
            StRtypeEx: state_d = StRtypeWb;
            StRtypeWb: state_d = StFetch;
            StBeqEx:   state_d = StFetch;
            StAddiEx:  state_d = StAddiWb;
            StAddiWb:  state_d = StFetch;
            StJEx:     state_d = StFetch;
            default:   state_d = StFetch;
        endcase
    end

    // Select values for the state being entered.
    always_comb begin
        iord_d     = 1'b0;
        memtoreg_d = 1'b0;
        regdst_d   = 1'b0;
        alusrca_d  = 1'b0;
        alusrcb_d  = 2'b00;
        pcsrc_d    = 2'b00;
        aluop_d    = 2'b00;
        unique case (state_d)
            StFetch:   alusrcb_d = 2'b01;
            StDecode:  alusrcb_d = 2'b11;
            StMemAdr: begin
                alusrca_d = 1'b1;
                alusrcb_d = 2'b10;
            end
            StMemRd:   iord_d = 1'b1;
            StMemWb:   memtoreg_d = 1'b1;
            StMemWr:   iord_d = 1'b1;
            StRtypeEx: begin
                alusrca_d = 1'b1;
                aluop_d   = 2'b10;
            end
            StRtypeWb: regdst_d = 1'b1;
            StBeqEx: begin
                alusrca_d = 1'b1;
                aluop_d   = 2'b01;
                pcsrc_d   = 2'b01;
            end
            StAddiEx: begin
                alusrca_d = 1'b1;
                alusrcb_d = 2'b10;
            end
            StAddiWb:  begin
            end
            StJEx:     pcsrc_d = 2'b10;
            default:   alusrcb_d = 2'b01;
        endcase
    end

    // An instruction retires on the edge that returns to FETCH, except the
    // illegal-opcode path out of DECODE.
    always_comb begin
        retire = 1'b0;
        unique case (state_q)
            StMemWb, StRtypeWb, StBeqEx, StAddiWb, StJEx: retire = 1'b1;
            StMemWr:                                      retire = memready;
            default:                                      retire = 1'b0;
        endcase
        instret_d = retire ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StFetch;
            instret_q  <= 32'd0;
            iord_q     <= 1'b0;
            memtoreg_q <= 1'b0;
            regdst_q   <= 1'b0;
            alusrca_q  <= 1'b0;
            alusrcb_q  <= 2'b01;
            pcsrc_q    <= 2'b00;
            aluop_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            instret_q  <= instret_d;
            iord_q     <= iord_d;
            memtoreg_q <= memtoreg_d;
            regdst_q   <= regdst_d;
            alusrca_q  <= alusrca_d;
            alusrcb_q  <= alusrcb_d;
            pcsrc_q    <= pcsrc_d;
            aluop_q    <= aluop_d;
        end
    end

    // Strobes are decoded from the current state and gated by reset so none
    // can fire while reset is low, even before the next clock edge.
    always_comb begin
        pcwrite  = ((state_q == StFetch) && memready) || (state_q == StJEx);
        branch   = (state_q == StBeqEx);
        irwrite  = reset && (state_q == StFetch) && memready;
        memwrite = reset && (state_q == StMemWr) && memready;
        regwrite = reset && ((state_q == StMemWb) || (state_q == StRtypeWb) ||
                             (state_q == StAddiWb));
        pcen     = reset && (pcwrite || (branch && zero));
        illegal  = reset && (state_q == StDecode) && !op_legal;
    end

    // ALU decoder.
    always_comb begin
        alucontrol = 3'b010;
        unique case (aluop_q)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                unique case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign iord     = iord_q;
    assign memtoreg = memtoreg_q;
    assign regdst   = regdst_q;
    assign alusrca  = alusrca_q;
    assign alusrcb  = alusrcb_q;
    assign pcsrc    = pcsrc_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed steps then randomized instructions, each
// checked against an instruction-level model (cycle counts, strobe counts and
// positions, ALU operation, retire count).
module tb_mc_controller;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        memready = 1'b1;
    logic        pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic        illegal;
    logic [31:0] instret;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memready   (memready),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] o);
        return (o == OpLw) || (o == OpSw) || (o == OpRtype) || (o == OpBeq) ||
               (o == OpAddi) || (o == OpJ);
    endfunction

    function automatic logic [2:0] ref_rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Runs one instruction from the start of its FETCH cycle. sf = fetch stall
    // cycles, sm = memory stall cycles (lw/sw only). Entered and left at a
    // point just after a falling edge.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int sf, input int sm);
        logic        is_lw, is_sw, is_r, is_beq, is_addi, is_j, is_ill, is_mem;
        int          base, total, mem_start;
        int          ir_cnt, ir_idx, pc_cnt, rw_cnt, rw_idx, mw_cnt, mw_idx, il_cnt, il_idx;
        logic        mt_at_rw, rd_at_rw;
        logic [2:0]  alu_ex;
        logic [1:0]  pcsrc_ex;
        logic [31:0] ir0;
        logic        mr;
        is_lw   = (o == OpLw);
        is_sw   = (o == OpSw);
        is_r    = (o == OpRtype);
        is_beq  = (o == OpBeq);
        is_addi = (o == OpAddi);
        is_j    = (o == OpJ);
        is_ill  = !is_legal(o);
        is_mem  = is_lw || is_sw;
        base = is_lw ? 5 : (is_sw || is_r || is_addi) ? 4 : (is_beq || is_j) ? 3 : 2;
        total = base + sf + (is_mem ? sm : 0);
        mem_start = sf + 3;
        ir_cnt = 0; ir_idx = -1; pc_cnt = 0; rw_cnt = 0; rw_idx = -1;
        mw_cnt = 0; mw_idx = -1; il_cnt = 0; il_idx = -1;
        mt_at_rw = 1'b0; rd_at_rw = 1'b0; alu_ex = 3'b000; pcsrc_ex = 2'b00; ir0 = 32'd0;
        op = o;
        funct = f;
        zero = z;
        for (int c = 0; c < total; c++) begin
            if (c < sf) mr = 1'b0;
            else if (c == sf) mr = 1'b1;
            else if (is_mem && c >= mem_start && c < mem_start + sm) mr = 1'b0;
            else if (is_mem && c == mem_start + sm) mr = 1'b1;
            else mr = 1'($urandom_range(0, 1));
            memready = mr;
            #1;
            if (c == 0) ir0 = instret;
            if (irwrite) begin ir_cnt++; if (ir_idx < 0) ir_idx = c; end
            if (pcen) pc_cnt++;
            if (regwrite) begin
                rw_cnt++;
                if (rw_idx < 0) begin rw_idx = c; mt_at_rw = memtoreg; rd_at_rw = regdst; end
            end
            if (memwrite) begin mw_cnt++; if (mw_idx < 0) mw_idx = c; end
            if (illegal) begin il_cnt++; if (il_idx < 0) il_idx = c; end
            if (c == sf + 2) begin alu_ex = alucontrol; pcsrc_ex = pcsrc; end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk({name, " irwrite count"}, ir_cnt, 1);
        chk({name, " irwrite cycle"}, ir_idx, sf);
        chk({name, " pcen count"}, pc_cnt, 1 + (is_j ? 1 : 0) + ((is_beq && z) ? 1 : 0));
        chk({name, " regwrite count"}, rw_cnt, (is_lw || is_r || is_addi) ? 1 : 0);
        if (is_lw || is_r || is_addi) begin
            chk({name, " regwrite cycle"}, rw_idx, is_lw ? sf + 4 + sm : sf + 3);
            chk({name, " memtoreg"}, 32'(mt_at_rw), 32'(is_lw));
            chk({name, " regdst"}, 32'(rd_at_rw), 32'(is_r));
        end
        chk({name, " memwrite count"}, mw_cnt, is_sw ? 1 : 0);
        if (is_sw) chk({name, " memwrite cycle"}, mw_idx, sf + 3 + sm);
        chk({name, " illegal count"}, il_cnt, is_ill ? 1 : 0);
        if (is_ill) chk({name, " illegal cycle"}, il_idx, sf + 1);
        if (!is_j && !is_ill)
            chk({name, " alucontrol"}, 32'(alu_ex),
                32'(is_r ? ref_rtype_alu(f) : is_beq ? 3'b110 : 3'b010));
        if (is_beq) chk({name, " pcsrc"}, 32'(pcsrc_ex), 32'd1);
        if (is_j) chk({name, " pcsrc"}, 32'(pcsrc_ex), 32'd2);
        chk({name, " instret"}, instret, ir0 + (is_ill ? 32'd0 : 32'd1));
    endtask

    initial begin
        logic [31:0] ir_keep;
        logic [5:0]  ro, rf;
        logic [5:0]  fl [5];
        fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100;
        fl[3] = 6'b100101; fl[4] = 6'b101010;

        // Reset held for three cycles with memready high.
        #2;
        reset = 1'b0;
        memready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("reset pcen", 32'(pcen), 32'd0);
            chk("reset irwrite", 32'(irwrite), 32'd0);
            chk("reset regwrite", 32'(regwrite), 32'd0);
            chk("reset memwrite", 32'(memwrite), 32'd0);
            chk("reset illegal", 32'(illegal), 32'd0);
            chk("reset instret", instret, 32'd0);
            chk("reset alusrcb", 32'(alusrcb), 32'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        op = OpLw;
        #1;
        chk("first fetch irwrite", 32'(irwrite), 32'd1);
        chk("first fetch pcen", 32'(pcen), 32'd1);

        // Directed instructions.
        run_instr("lw", OpLw, 6'd0, 1'b0, 0, 0);
        run_instr("sw stall", OpSw, 6'd0, 1'b0, 0, 2);
        run_instr("beq taken", OpBeq, 6'd0, 1'b1, 0, 0);
        run_instr("beq not taken", OpBeq, 6'd0, 1'b0, 0, 0);
        run_instr("slt", OpRtype, 6'b101010, 1'b0, 0, 0);
        run_instr("and", OpRtype, 6'b100100, 1'b1, 0, 0);
        run_instr("illegal", 6'b111111, 6'd0, 1'b0, 0, 0);
        run_instr("lw fetch stall", OpLw, 6'd0, 1'b0, 2, 1);
        run_instr("j", OpJ, 6'd0, 1'b1, 0, 0);

        // Reset asserted in the middle of an addi.
        op = OpAddi;
        memready = 1'b1;
        #1;
        ir_keep = instret;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("addiex alusrcb", 32'(alusrcb), 32'd2);
        reset = 1'b0;
        #1;
        chk("mid reset regwrite", 32'(regwrite), 32'd0);
        chk("mid reset pcen", 32'(pcen), 32'd0);
        chk("mid reset alusrcb", 32'(alusrcb), 32'd1);
        chk("mid reset instret", instret, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("held reset regwrite", 32'(regwrite), 32'd0);
        chk("held reset instret", instret, 32'd0);
        reset = 1'b1;
        run_instr("addi after reset", OpAddi, 6'd0, 1'b0, 0, 0);
        chk("instret restarted", instret, (ir_keep == 32'd0) ? 32'd1 : 32'd1);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: ro = OpLw;
                1: ro = OpSw;
                2: ro = OpRtype;
                3: ro = OpBeq;
                4: ro = OpAddi;
                5: ro = OpJ;
                default: begin
                    ro = 6'($urandom);
                    while (is_legal(ro)) ro = 6'($urandom);
                end
            endcase
            if ($urandom_range(0, 4) == 0) rf = 6'($urandom);
            else rf = fl[$urandom_range(0, 4)];
            run_instr($sformatf("rand%0d op%02h", n, ro), ro, rf, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
